// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-to-one arbiter that shares one downstream memory bus between the CPU
// instruction-fetch port (inst_*) and the load/store port (data_*). The
// selected request is forwarded combinationally (zero added latency). The
// grant is held for the whole of a multi-cycle transaction while the
// downstream slave stalls. A requesting port that does not hold the bus sees
// stall = 1.
//
// Handshake: a port requests while read | write = 1 and holds address, read,
// write, data_wr and mask stable until it sees its own stall = 0. That cycle
// completes the access; read data (data_rd / data_rd_2) is valid for the port
// that sees stall = 0 with read = 1. The same rule applies between mem_* and
// the downstream slave.
//
// Parameters
//   ROUND_ROBIN  1: simultaneous new requests alternate between ports.
//                0: the data port always wins a tie.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   inst_*              upstream instruction-fetch master (slave side)
//   data_*              upstream load/store master (slave side)
//   mem_*               downstream shared bus (master side)
//   dbg_locked          registered lock flag
//   dbg_owner           registered owner of a locked transaction (0 inst, 1 data)
//   dbg_last            registered most recently granted port (0 inst, 1 data)
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch port
  input  logic [31:0] inst_address,
  input  logic        inst_read,
  input  logic        inst_write,
  input  logic [31:0] inst_data_wr,
  input  logic [3:0]  inst_mask,
  output logic        inst_stall,
  output logic [31:0] inst_data_rd,
  output logic [31:0] inst_data_rd_2,
  // data port
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_data_wr,
  input  logic [3:0]  data_mask,
  output logic        data_stall,
  output logic [31:0] data_data_rd,
  output logic [31:0] data_data_rd_2,
  // downstream bus
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_data_wr,
  output logic [3:0]  mem_mask,
  input  logic        mem_stall,
  input  logic [31:0] mem_data_rd,
  input  logic [31:0] mem_data_rd_2,
  // state visibility
  output logic        dbg_locked,
  output logic        dbg_owner,
  output logic        dbg_last
);

  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } port_e;

  logic  locked_q, locked_d;
  port_e owner_q, owner_d;
  port_e last_q, last_d;

  logic  inst_req, data_req;
  port_e grant;
  logic  grant_valid;

  // Grant selection. While locked the grant is pinned to the owner; if the
  // owner has withdrawn its request the grant is not valid, so nothing is
  // forwarded and the lock falls away at the next edge.
  always_comb begin
    inst_req    = inst_read | inst_write;
    data_req    = data_read | data_write;
    grant       = PORT_INST;
    grant_valid = 1'b0;
    if (rst) begin
      grant_valid = 1'b0;
    end else if (locked_q) begin
      grant       = owner_q;
      grant_valid = (owner_q == PORT_INST) ? inst_req : data_req;
    end else if (inst_req && data_req) begin
      if (ROUND_ROBIN != 0) begin
        grant = (last_q == PORT_INST) ? PORT_DATA : PORT_INST;
      end else begin
        grant = PORT_DATA;
      end
      grant_valid = 1'b1;
    end else if (inst_req) begin
      grant       = PORT_INST;
      grant_valid = 1'b1;
    end else if (data_req) begin
      grant       = PORT_DATA;
      grant_valid = 1'b1;
    end
  end

  // Downstream forwarding: all-zero bus when nothing is granted.
  always_comb begin
    mem_address = 32'h0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_data_wr = 32'h0;
    mem_mask    = 4'h0;
    if (grant_valid) begin
      if (grant == PORT_INST) begin
        mem_address = inst_address;
        mem_read    = inst_read;
        mem_write   = inst_write;
        mem_data_wr = inst_data_wr;
        mem_mask    = inst_mask;
      end else begin
        mem_address = data_address;
        mem_read    = data_read;
        mem_write   = data_write;
        mem_data_wr = data_data_wr;
        mem_mask    = data_mask;
      end
    end
  end

  // Upstream stall: the granted port follows the slave, a waiting requester
  // is held off, an idle port is never stalled. Reset holds both off.
  always_comb begin
    inst_stall = 1'b0;
    data_stall = 1'b0;
    if (rst) begin
      inst_stall = 1'b1;
      data_stall = 1'b1;
    end else begin
      if (inst_req) begin
        inst_stall = (grant_valid && grant == PORT_INST) ? mem_stall : 1'b1;
      end
      if (data_req) begin
        data_stall = (grant_valid && grant == PORT_DATA) ? mem_stall : 1'b1;
      end
    end
  end

  // Read data is broadcast; each port qualifies it with its own stall.
  assign inst_data_rd   = mem_data_rd;
  assign inst_data_rd_2 = mem_data_rd_2;
  assign data_data_rd   = mem_data_rd;
  assign data_data_rd_2 = mem_data_rd_2;

  // Next state. Without a valid grant only the lock changes (it clears).
  always_comb begin
    locked_d = 1'b0;
    owner_d  = owner_q;
    last_d   = last_q;
    if (grant_valid) begin
      last_d = grant;
      if (mem_stall) begin
        locked_d = 1'b1;
        owner_d  = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= 1'b0;
      owner_q  <= PORT_INST;
      last_q   <= PORT_INST;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
    end
  end

  assign dbg_locked = locked_q;
  assign dbg_owner  = owner_q;
  assign dbg_last   = last_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Drives two arbiters from the same stimulus: dut_a with ROUND_ROBIN=1 and
// dut_b with ROUND_ROBIN=0. Every cycle both are compared against a
// transaction-level reference model; directed steps add explicit checks of
// the scenarios of interest, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- stimulus
  logic [31:0] i_addr, i_wd, d_addr, d_wd;
  logic        i_rd, i_wr, d_rd, d_wr;
  logic [3:0]  i_mask, d_mask;
  logic        m_stall;
  logic [31:0] m_rd, m_rd2;

  // ---------------------------------------------------------------- DUT outputs
  logic        a_i_stall, a_d_stall, a_m_rd, a_m_wr, a_locked, a_owner, a_last;
  logic [31:0] a_i_drd, a_i_drd2, a_d_drd, a_d_drd2, a_m_addr, a_m_wd;
  logic [3:0]  a_m_mask;
  logic        b_i_stall, b_d_stall, b_m_rd, b_m_wr, b_locked, b_owner, b_last;
  logic [31:0] b_i_drd, b_i_drd2, b_d_drd, b_d_drd2, b_m_addr, b_m_wd;
  logic [3:0]  b_m_mask;

  bus_arbiter #(.ROUND_ROBIN(1)) dut_a (
    .clk(clk), .rst(rst),
    .inst_address(i_addr), .inst_read(i_rd), .inst_write(i_wr),
    .inst_data_wr(i_wd), .inst_mask(i_mask), .inst_stall(a_i_stall),
    .inst_data_rd(a_i_drd), .inst_data_rd_2(a_i_drd2),
    .data_address(d_addr), .data_read(d_rd), .data_write(d_wr),
    .data_data_wr(d_wd), .data_mask(d_mask), .data_stall(a_d_stall),
    .data_data_rd(a_d_drd), .data_data_rd_2(a_d_drd2),
    .mem_address(a_m_addr), .mem_read(a_m_rd), .mem_write(a_m_wr),
    .mem_data_wr(a_m_wd), .mem_mask(a_m_mask), .mem_stall(m_stall),
    .mem_data_rd(m_rd), .mem_data_rd_2(m_rd2),
    .dbg_locked(a_locked), .dbg_owner(a_owner), .dbg_last(a_last)
  );

  bus_arbiter #(.ROUND_ROBIN(0)) dut_b (
    .clk(clk), .rst(rst),
    .inst_address(i_addr), .inst_read(i_rd), .inst_write(i_wr),
    .inst_data_wr(i_wd), .inst_mask(i_mask), .inst_stall(b_i_stall),
    .inst_data_rd(b_i_drd), .inst_data_rd_2(b_i_drd2),
    .data_address(d_addr), .data_read(d_rd), .data_write(d_wr),
    .data_data_wr(d_wd), .data_mask(d_mask), .data_stall(b_d_stall),
    .data_data_rd(b_d_drd), .data_data_rd_2(b_d_drd2),
    .mem_address(b_m_addr), .mem_read(b_m_rd), .mem_write(b_m_wr),
    .mem_data_wr(b_m_wd), .mem_mask(b_m_mask), .mem_stall(m_stall),
    .mem_data_rd(m_rd), .mem_data_rd_2(m_rd2),
    .dbg_locked(b_locked), .dbg_owner(b_owner), .dbg_last(b_last)
  );

  // ---------------------------------------------------------------- scoreboard
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // Per instance k (0: round robin, 1: data priority): whether a transaction is
  // in progress (slave stalled it), who is running it, and who was served last.
  // Ports are numbered 0 = inst, 1 = data.
  bit          busy[2];
  int          busy_port[2];
  int          last_p[2];
  bit          act[2];
  int          win[2];
  logic [31:0] e_addr[2], e_wd[2];
  logic        e_rd[2], e_wr[2], e_is[2], e_ds[2];
  logic [3:0]  e_mask[2];

  task automatic model_eval(input int k);
    bit ireq, dreq;
    ireq = i_rd | i_wr;
    dreq = d_rd | d_wr;
    act[k] = 1'b0;
    win[k] = 0;
    if (busy[k]) begin
      win[k] = busy_port[k];
      act[k] = (win[k] == 0) ? ireq : dreq;
    end else if (ireq && dreq) begin
      act[k] = 1'b1;
      if (k == 0) win[k] = (last_p[k] == 0) ? 1 : 0;
      else        win[k] = 1;
    end else if (ireq) begin
      act[k] = 1'b1;
      win[k] = 0;
    end else if (dreq) begin
      act[k] = 1'b1;
      win[k] = 1;
    end
    if (rst) act[k] = 1'b0;
    e_addr[k] = 32'h0; e_rd[k] = 1'b0; e_wr[k] = 1'b0; e_wd[k] = 32'h0; e_mask[k] = 4'h0;
    if (act[k] && win[k] == 0) begin
      e_addr[k] = i_addr; e_rd[k] = i_rd; e_wr[k] = i_wr; e_wd[k] = i_wd; e_mask[k] = i_mask;
    end else if (act[k]) begin
      e_addr[k] = d_addr; e_rd[k] = d_rd; e_wr[k] = d_wr; e_wd[k] = d_wd; e_mask[k] = d_mask;
    end
    e_is[k] = !ireq ? 1'b0 : (act[k] && win[k] == 0) ? m_stall : 1'b1;
    e_ds[k] = !dreq ? 1'b0 : (act[k] && win[k] == 1) ? m_stall : 1'b1;
    if (rst) begin
      e_is[k] = 1'b1;
      e_ds[k] = 1'b1;
    end
  endtask

  task automatic model_update(input int k);
    if (rst) begin
      busy[k] = 1'b0; busy_port[k] = 0; last_p[k] = 0;
    end else if (act[k]) begin
      last_p[k]    = win[k];
      busy[k]      = m_stall;
      busy_port[k] = win[k];
    end else begin
      busy[k] = 1'b0;
    end
  endtask

  task automatic check_dut(input int k, input logic [31:0] addr, input logic rd, input logic wr,
                           input logic [31:0] wd, input logic [3:0] mask, input logic is,
                           input logic ds, input logic [31:0] idrd, input logic [31:0] idrd2,
                           input logic [31:0] ddrd, input logic [31:0] ddrd2);
    chk($sformatf("mem_read%0d", k),   {31'h0, rd}, {31'h0, e_rd[k]});
    chk($sformatf("mem_write%0d", k),  {31'h0, wr}, {31'h0, e_wr[k]});
    chk($sformatf("inst_stall%0d", k), {31'h0, is}, {31'h0, e_is[k]});
    chk($sformatf("data_stall%0d", k), {31'h0, ds}, {31'h0, e_ds[k]});
    if (!rst) begin
      chk($sformatf("mem_address%0d", k), addr, e_addr[k]);
      chk($sformatf("mem_data_wr%0d", k), wd, e_wd[k]);
      chk($sformatf("mem_mask%0d", k), {28'h0, mask}, {28'h0, e_mask[k]});
    end
    chk($sformatf("inst_data_rd%0d", k), idrd, m_rd);
    chk($sformatf("inst_data_rd_2_%0d", k), idrd2, m_rd2);
    chk($sformatf("data_data_rd%0d", k), ddrd, m_rd);
    chk($sformatf("data_data_rd_2_%0d", k), ddrd2, m_rd2);
  endtask

  // Completion flags of the round-robin instance, used by the random masters.
  bit done_i, done_d, was_rst;

  // One clock cycle: compare outputs mid-cycle, advance the model, then check
  // the registered state just after the edge.
  task automatic tick();
    @(negedge clk);
    model_eval(0);
    model_eval(1);
    check_dut(0, a_m_addr, a_m_rd, a_m_wr, a_m_wd, a_m_mask, a_i_stall, a_d_stall,
              a_i_drd, a_i_drd2, a_d_drd, a_d_drd2);
    check_dut(1, b_m_addr, b_m_rd, b_m_wr, b_m_wd, b_m_mask, b_i_stall, b_d_stall,
              b_i_drd, b_i_drd2, b_d_drd, b_d_drd2);
    done_i  = !rst && (i_rd | i_wr) && !e_is[0];
    done_d  = !rst && (d_rd | d_wr) && !e_ds[0];
    was_rst = rst;
    model_update(0);
    model_update(1);
    @(posedge clk);
    #1;
    chk("locked0", {31'h0, a_locked}, {31'h0, busy[0]});
    chk("locked1", {31'h0, b_locked}, {31'h0, busy[1]});
    chk("last0", {31'h0, a_last}, last_p[0]);
    chk("last1", {31'h0, b_last}, last_p[1]);
    if (busy[0]) chk("owner0", {31'h0, a_owner}, busy_port[0]);
    if (busy[1]) chk("owner1", {31'h0, b_owner}, busy_port[1]);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic inst_idle();
    i_rd = 1'b0; i_wr = 1'b0; i_addr = 32'h0; i_wd = 32'h0; i_mask = 4'h0;
  endtask

  task automatic data_idle();
    d_rd = 1'b0; d_wr = 1'b0; d_addr = 32'h0; d_wd = 32'h0; d_mask = 4'h0;
  endtask

  task automatic inst_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] m);
    i_rd = rd; i_wr = wr; i_addr = a; i_wd = wd; i_mask = m;
  endtask

  task automatic data_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] m);
    d_rd = rd; d_wr = wr; d_addr = a; d_wd = wd; d_mask = m;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inst_idle();
    data_idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    for (int k = 0; k < 2; k++) begin
      busy[k] = 1'b0; busy_port[k] = 0; last_p[k] = 0;
    end
    rst = 1'b1; m_stall = 1'b0; m_rd = 32'h0; m_rd2 = 32'h0;
    inst_idle();
    data_idle();
    #1;
    chk("rst_inst_stall", {31'h0, a_i_stall}, 32'h1);
    chk("rst_data_stall", {31'h0, a_d_stall}, 32'h1);
    do_reset();
    chk("reset_locked", {31'h0, a_locked}, 32'h0);
    chk("reset_last", {31'h0, a_last}, 32'h0);

    // Single-cycle slave, inst read only.
    inst_req(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
    m_stall = 1'b0; m_rd = 32'h1234_5678; m_rd2 = 32'h9ABC_DEF0;
    #1;
    chk("t1_addr", a_m_addr, 32'h8000_0000);
    chk("t1_read", {31'h0, a_m_rd}, 32'h1);
    chk("t1_inst_stall", {31'h0, a_i_stall}, 32'h0);
    chk("t1_data_rd", a_i_drd, 32'h1234_5678);
    tick();
    inst_idle();

    // Simultaneous reads right after reset: data first, then inst.
    do_reset();
    inst_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    data_req(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
    #1;
    chk("t2_c0_addr", a_m_addr, 32'h0000_0200);
    chk("t2_c0_inst_stall", {31'h0, a_i_stall}, 32'h1);
    chk("t2_c0_data_stall", {31'h0, a_d_stall}, 32'h0);
    tick();
    data_idle();
    #1;
    chk("t2_c1_addr", a_m_addr, 32'h0000_0100);
    chk("t2_c1_inst_stall", {31'h0, a_i_stall}, 32'h0);
    tick();

    // Continuous contention: data-priority instance never serves inst.
    data_req(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("t2_fixed_addr", b_m_addr, 32'h0000_0200);
      chk("t2_fixed_inst_stall", {31'h0, b_i_stall}, 32'h1);
      tick();
    end
    inst_idle();
    data_idle();
    tick();

    // Data write stalled for 3 cycles; inst arrives in cycle 1, served in 4.
    data_req(1'b0, 1'b1, 32'h0300_0000, 32'h41, 4'b0001);
    for (int c = 0; c < 4; c++) begin
      m_stall = (c < 3);
      if (c == 1) inst_req(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
      #1;
      chk("t3_addr", a_m_addr, 32'h0300_0000);
      chk("t3_write", {31'h0, a_m_wr}, 32'h1);
      chk("t3_data_wr", a_m_wd, 32'h41);
      if (c >= 1) chk("t3_inst_stall", {31'h0, a_i_stall}, 32'h1);
      tick();
    end
    data_idle();
    m_stall = 1'b0;
    #1;
    chk("t3_c4_addr", a_m_addr, 32'h0000_2000);
    chk("t3_c4_inst_stall", {31'h0, a_i_stall}, 32'h0);
    tick();
    inst_idle();

    // Mask / write-data pass-through, then an idle all-zero bus.
    data_req(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1100);
    #1;
    chk("t4_mask", {28'h0, a_m_mask}, 32'hC);
    chk("t4_data_wr", a_m_wd, 32'hDEAD_BEEF);
    tick();
    data_idle();
    #1;
    chk("t4_idle_addr", a_m_addr, 32'h0);
    chk("t4_idle_wd", a_m_wd, 32'h0);
    chk("t4_idle_ctl", {27'h0, a_m_mask, a_m_rd}, 32'h0);
    tick();

    // Reset in the second cycle of a stalled inst read.
    inst_req(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF);
    m_stall = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("t5_read", {31'h0, a_m_rd}, 32'h0);
    chk("t5_inst_stall", {31'h0, a_i_stall}, 32'h1);
    chk("t5_data_stall", {31'h0, a_d_stall}, 32'h1);
    tick();
    rst = 1'b0;
    inst_idle();
    data_req(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'hF);
    m_stall = 1'b0;
    #1;
    chk("t5_after_locked", {31'h0, a_locked}, 32'h0);
    chk("t5_after_addr", a_m_addr, 32'h0000_5000);
    chk("t5_after_data_stall", {31'h0, a_d_stall}, 32'h0);
    tick();
    data_idle();

    // Owner withdraws its request while locked.
    inst_req(1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'hF);
    m_stall = 1'b1;
    tick();
    chk("t6_locked", {31'h0, a_locked}, 32'h1);
    inst_idle();
    data_req(1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'hF);
    m_stall = 1'b0;
    #1;
    chk("t6_read", {31'h0, a_m_rd}, 32'h0);
    chk("t6_data_stall", {31'h0, a_d_stall}, 32'h1);
    tick();
    chk("t6_unlocked", {31'h0, a_locked}, 32'h0);
    #1;
    chk("t6_next_addr", a_m_addr, 32'h0000_7000);
    tick();
    data_idle();
    tick();

    // Randomized traffic with protocol-following masters.
    done_i = 1'b1;
    done_d = 1'b1;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (was_rst) begin
        inst_idle();
        data_idle();
      end
      if (!(i_rd | i_wr) || done_i) begin
        if ($urandom_range(0, 2) != 0) begin
          inst_req($urandom_range(0, 3) != 0, 1'b0, $urandom, $urandom, 4'($urandom_range(0, 15)));
          if (!i_rd) i_wr = 1'b1;
        end else begin
          inst_idle();
        end
      end else if ($urandom_range(0, 39) == 0) begin
        inst_idle();
      end
      if (!(d_rd | d_wr) || done_d) begin
        if ($urandom_range(0, 2) != 0) begin
          d_rd = $urandom_range(0, 1);
          data_req(d_rd, !d_rd, $urandom, $urandom, 4'($urandom_range(0, 15)));
        end else begin
          data_idle();
        end
      end else if ($urandom_range(0, 39) == 0) begin
        data_idle();
      end
      m_stall = ($urandom_range(0, 2) == 0);
      m_rd    = $urandom;
      m_rd2   = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-to-one arbiter sharing a single downstream memory bus between the CPU instruction-fetch port and the data-access port. It presents two `Bus_if.slave` ports upstream and one `Bus_if.master` port downstream. It forwards the selected master's request with zero added latency and holds the grant for the whole multi-cycle transaction while the downstream slave stalls. Other masters see `stall` until they are served. It sits between the CPU core and the address decoder that fans out to RAM, flash, UART, timer, graphics and the other peripherals.

## Interface
- `ROUND_ROBIN`, default 1: when 1, simultaneous new requests alternate between ports. When 0, the data port always wins a tie.
- `clk`  input  `Clock_t`  clock bundle. All state updates on the rising edge of `clk.base`. `clk.rst` is the reset: synchronous, active-high.
- `inst_bus`  `Bus_if.slave`  upstream instruction-fetch master (reads only in practice; writes are still forwarded).
- `data_bus`  `Bus_if.slave`  upstream load/store master.
- `mem_bus`  `Bus_if.master`  downstream shared bus (`address`, `read`, `write`, `data_wr`, `mask` out; `stall`, `data_rd`, `data_rd_2` in).

## Operation
- A port requests when its `read | write` is 1. A requester holds `address`, `read`, `write`, `data_wr` and `mask` stable until it sees its own `stall` = 0.
- State registers:
  - `locked` (1 bit).
  - `owner` ∈ {INST, DATA}.
  - `last` ∈ {INST, DATA}: the most recently granted port.
- Current-cycle grant `g`, combinational:
  - If `locked`: `g = owner`.
  - Else, only one port requesting: `g` = that port.
  - Else, both requesting: with ROUND_ROBIN=1, `g` = the port ≠ `last`; with ROUND_ROBIN=0, `g` = DATA.
  - Else: no grant.
- Forwarding:
  - `mem_bus.{address,read,write,data_wr,mask}` are copied from the granted port.
  - With no grant: `read = write = 0`, `address = 0`, `data_wr = 0`, `mask = 0`.
- Upstream stall:
  - Granted port: `stall = mem_bus.stall`.
  - Non-granted port that is requesting: `stall = 1`.
  - Non-requesting port: `stall = 0`.
- Read data: `mem_bus.data_rd` and `data_rd_2` are broadcast to both ports. The data is valid only for the port seeing `stall` = 0 with `read` = 1.
- Register update each edge, when a grant exists:
  - `last <= g`.
  - If `mem_bus.stall` = 1: `locked <= 1`, `owner <= g`.
  - If `mem_bus.stall` = 0: `locked <= 0`. The transaction completed this cycle.
- With no grant, all registers hold, except that `locked` is forced to 0.
- Once locked, the grant cannot switch, even if the owner deasserts its request (protocol violation). In that case `read`/`write` drop downstream, `locked` clears on the next edge, and the slave must tolerate the aborted access.

## Timing
- Reset (`clk.rst` = 1 at an edge): `locked <= 0`, `owner <= INST`, `last <= INST`. The first tie after reset therefore goes to DATA.
- While `clk.rst` = 1, outputs are forced:
  - `mem_bus.read` = `mem_bus.write` = 0.
  - `inst_bus.stall` = `data_bus.stall` = 1.
- Reset mid-transaction:
  - The downstream request drops in the same cycle `rst` is seen.
  - The lock clears at that edge.
  - The upstream masters are reset alongside and must re-issue.
- Added latency is 0 cycles. A single-cycle slave (`stall` = 0) completes each access in the cycle it is presented.
- Back-to-back: the port finishing in cycle N may be granted again in N+1 only if the other port is not requesting (ROUND_ROBIN=1).
- With ROUND_ROBIN=1 and both ports requesting continuously, the worst-case wait for either port is one competing transaction.

## Test plan
- Single-cycle slave, `inst_bus` only, read at 0x8000_0000:
  - `mem_bus.address` = 0x8000_0000, `read` = 1 in the same cycle.
  - `inst_bus.stall` = 0; `data_rd` returned.
- Both ports issue reads on the same cycle right after reset, ROUND_ROBIN=1:
  - DATA is served in cycle 0 and INST in cycle 1; `inst_bus.stall` = 1 in cycle 0.
  - With ROUND_ROBIN=0 and DATA requesting continuously, INST never wins.
- Slave stalls 3 cycles on a DATA write (0x0300_0000, `mask` = 4'b0001, `data_wr` = 0x41); INST requests in cycle 1:
  - Grant stays DATA for cycles 0-3; `inst_bus.stall` = 1 throughout.
  - INST is granted in cycle 4.
- `mask` and `data_wr` pass-through: DATA write with `mask` = 4'b1100, `data_wr` = 0xDEAD_BEEF:
  - Identical values appear on `mem_bus`.
  - With no requester, `mem_bus` is all zeros.
- Reset asserted in the 2nd cycle of a stalled INST read:
  - `mem_bus.read` = 0 and both upstream stalls = 1 that cycle.
  - After reset, a DATA request is granted immediately; the lock is gone.
- Owner drops `read` while locked: `mem_bus.read` = 0 that cycle and `locked` = 0 on the next edge.
